// File: rtl/arb_mux.sv
// arb_mux: registered M-input stream multiplexer with built-in arbitration.
// Each cycle one requesting channel is granted. Its word is registered into a
// single-entry output stage, together with the index of the winning channel.
//
// Build option ARB_MUX_RR_EN:
//   defined   -> round-robin search that starts at ptr and moves upward mod M
//   undefined -> fixed priority (lowest valid index wins); ptr is not built
//
// Output stage states:
//   state   | meaning
//   S_EMPTY | no word held, out_valid=0, a load is always possible
//   S_FULL  | word held, out_valid=1, a load is possible only when out_ready=1
module arb_mux #(
  parameter int N    = 32,
  parameter int M    = 4,
  parameter int SELW = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [M*N-1:0]    in_data,
  input  logic [M-1:0]      in_valid,
  output logic [M-1:0]      in_ready,
  output logic [N-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            can_load;
  logic            found;
  logic            load;
  logic [SELW-1:0] win;
  logic [M-1:0]    grant;

`ifdef ARB_MUX_RR_EN
  localparam int SW1 = SELW + 1;

  logic [SELW-1:0] ptr_q;
  logic [SW1-1:0]  cand;

  // Round-robin search: first valid channel at ptr, ptr+1, ... wrapping at M.
  // The extra bit on cand keeps the sum from overflowing before the wrap.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < M; k++) begin
      cand = {1'b0, ptr_q} + SW1'(k);
      if (cand >= SW1'(M)) cand = cand - SW1'(M);
      if (!found && in_valid[cand[SELW-1:0]]) begin
        found = 1'b1;
        win   = cand[SELW-1:0];
      end
    end
  end

  // Pointer moves to the channel after the winner on every load, wrapping at M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr_q <= '0;
    else if (load) ptr_q <= (win == SELW'(M - 1)) ? '0 : win + 1'b1;
  end
`else
  // Fixed priority: the lowest-index valid channel wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = M - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        found = 1'b1;
        win   = SELW'(k);
      end
    end
  end
`endif

  assign can_load  = (state_q == S_EMPTY) || out_ready;
  assign load      = can_load && found;
  assign out_valid = (state_q == S_FULL);

  // One-hot grant for the winner, zero when nobody requests.
  always_comb begin
    grant      = '0;
    grant[win] = found;
  end

  assign in_ready = grant & {M{can_load}};

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next state: a load always fills; a drain without a load empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (!load && out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Capture the winning word and its index on every load; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (load) begin
      out_data <= in_data[win*N +: N];
      out_sel  <= win;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: an M=4 and an M=3 instance checked against a
// behavioural model (search from a start channel modulo M).
module tb_arb_mux;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4*N-1:0] id4;
  logic [3:0]     iv4, ir4;
  logic [N-1:0]   od4;
  logic [1:0]     os4;
  logic           ov4, or4;

  logic [3*N-1:0] id3;
  logic [2:0]     iv3, ir3;
  logic [N-1:0]   od3;
  logic [1:0]     os3;
  logic           ov3, or3;

  arb_mux #(.N(N), .M(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(id4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_sel(os4), .out_valid(ov4), .out_ready(or4)
  );

  arb_mux #(.N(N), .M(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(id3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_sel(os3), .out_valid(ov3), .out_ready(or3)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit           mv[2];
  logic [N-1:0] md[2];
  int           ms[2];
  int           mp[2];
  int           mm[2] = '{4, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      mv[d] = 1'b0; md[d] = '0; ms[d] = 0; mp[d] = 0;
    end
  endtask

  function automatic int winner(input int d);
    logic [15:0] v;
    int start;
    v = (d == 0) ? 16'(iv4) : 16'(iv3);
`ifdef ARB_MUX_RR_EN
    start = mp[d];
`else
    start = 0;
`endif
    for (int k = 0; k < mm[d]; k++) begin
      int c;
      c = (start + k) % mm[d];
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] word(input int d, input int c);
    return (d == 0) ? id4[c*N +: N] : id3[c*N +: N];
  endfunction

  // One clock: check ready, clock the model and the DUTs, check outputs.
  task automatic tick;
    int           w[2];
    bit           cl[2];
    bit           rdy[2];
    logic [N-1:0] wd[2];
    #1;
    rdy[0] = or4;
    rdy[1] = or3;
    for (int d = 0; d < 2; d++) begin
      cl[d] = !mv[d] || rdy[d];
      w[d]  = winner(d);
      wd[d] = (w[d] >= 0) ? word(d, w[d]) : '0;
    end
    chk("in_ready_m4", 64'(ir4), (cl[0] && w[0] >= 0) ? (64'd1 << w[0]) : 64'd0);
    chk("in_ready_m3", 64'(ir3), (cl[1] && w[1] >= 0) ? (64'd1 << w[1]) : 64'd0);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (cl[d] && w[d] >= 0) begin
        mv[d] = 1'b1;
        md[d] = wd[d];
        ms[d] = w[d];
        mp[d] = (w[d] + 1) % mm[d];
      end else if (rdy[d]) begin
        mv[d] = 1'b0;
      end
    end
    #1;
    chk("out_valid_m4", 64'(ov4), 64'(mv[0]));
    chk("out_data_m4",  64'(od4), 64'(md[0]));
    chk("out_sel_m4",   64'(os4), 64'(ms[0]));
    chk("out_valid_m3", 64'(ov3), 64'(mv[1]));
    chk("out_data_m3",  64'(od3), 64'(md[1]));
    chk("out_sel_m3",   64'(os3), 64'(ms[1]));
    chk("sel_range_m3", 64'(os3 < 2'd3), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv4 = '0; id4 = '0; or4 = 1'b1;
    iv3 = '0; id3 = '0; or3 = 1'b1;
    model_reset();
    #8;
    chk("rst_valid_m4", 64'(ov4), 64'd0);
    chk("rst_data_m4",  64'(od4), 64'd0);
    chk("rst_sel_m4",   64'(os4), 64'd0);
    chk("rst_ready_m4", 64'(ir4), 64'd0);
    #4 rst_n = 1'b1;

    // idle after reset
    repeat (5) tick();

    // single request on channel 2
    iv4 = 4'b0100; id4[2*N +: N] = 32'hA5A5_0002;
    iv3 = 3'b100;  id3[2*N +: N] = 32'hA5A5_0002;
    tick();
    iv4 = '0; iv3 = '0;
    tick();

    // all channels requesting continuously
    for (int t = 0; t < 6; t++) begin
      iv4 = 4'b1111;
      for (int c = 0; c < 4; c++) id4[c*N +: N] = {16'hC0DE, 8'(t), 8'(c)};
      tick();
    end
    iv4 = '0;
    tick();

    // M=3: ch2 alone, then ch0 and ch2 together
    iv3 = 3'b100; id3[2*N +: N] = 32'h3333_0002;
    tick();
    iv3 = 3'b101; id3[0 +: N] = 32'h3333_0000; id3[2*N +: N] = 32'h3333_1002;
    tick();
    tick();
    tick();
    iv3 = '0;
    tick();

    // backpressure: hold for four cycles, then drain and reload together
    or4 = 1'b0; iv4 = 4'b0010; id4[1*N +: N] = 32'h1111_0001;
    tick();
    id4[1*N +: N] = 32'h1111_0002;
    repeat (4) tick();
    or4 = 1'b1;
    tick();
    iv4 = '0;
    tick();

    // asynchronous reset while full
    or4 = 1'b0; or3 = 1'b0; iv4 = 4'b1000; iv3 = 3'b010;
    id4[3*N +: N] = 32'hDEAD_0003; id3[1*N +: N] = 32'hDEAD_0001;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_valid_m4", 64'(ov4), 64'd0);
    chk("async_rst_valid_m3", 64'(ov3), 64'd0);
    chk("async_rst_data_m4",  64'(od4), 64'd0);
    #2 rst_n = 1'b1;
    or4 = 1'b1; or3 = 1'b1; iv4 = 4'b1010; iv3 = 3'b110;
    id4[1*N +: N] = 32'hBEEF_0001; id3[1*N +: N] = 32'hBEEF_0011;
    tick();
    iv4 = '0; iv3 = '0;
    tick();

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      iv4 = 4'($urandom_range(0, 15));
      iv3 = 3'($urandom_range(0, 7));
      for (int c = 0; c < 4; c++) id4[c*N +: N] = $urandom;
      for (int c = 0; c < 3; c++) id3[c*N +: N] = $urandom;
      or4 = ($urandom_range(0, 3) != 0);
      or3 = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
